// File: rtl/down_counter_timer_if.sv
// Control/status bundle for the loadable down counter timer.
// The master drives control strobes; the slave (the counter) returns status.
interface down_counter_timer_if #(
  parameter int WIDTH = 3
);
  logic             T;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             tc;
  logic             busy;

  modport master (
    output T,
    output load,
    output load_val,
    output auto_reload,
    input  out,
    input  zero,
    input  tc,
    input  busy
  );

  modport slave (
    input  T,
    input  load,
    input  load_val,
    input  auto_reload,
    output out,
    output zero,
    output tc,
    output busy
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down counter with terminal-count pulse.
// Stops at zero (one-shot) or reloads the start value (periodic).
module down_counter_timer #(
  parameter int WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  down_counter_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rel_q, rel_d;
  logic             zero_q, zero_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  logic step;
  logic last;

  // A load on the same edge pre-empts any decrement.
  assign step = !bus.load
             && (state_q == RUN)
             && bus.T;
  assign last = (cnt_q == WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rel_q   <= '0;
      zero_q  <= 1'b1;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      zero_q  <= zero_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    unique case (1'b1)
      bus.load: begin
        cnt_d   = bus.load_val;
        rel_d   = bus.load_val;
        state_d = (bus.load_val != '0)
                ? RUN : IDLE;
      end
      (step && last): begin
        if (bus.auto_reload) begin
          cnt_d = rel_q;
        end else begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      (step && !last): begin
        cnt_d = cnt_q - WIDTH'(1);
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    zero_d = (cnt_d == '0);
    busy_d = (state_d == RUN);
    tc_d   = step && last;
  end

  assign bus.out  = cnt_q;
  assign bus.zero = zero_q;
  assign bus.tc   = tc_q;
  assign bus.busy = busy_q;

endmodule
